hdmi_timing_pattern_gen: RTL and testbench

//  Parametrised video timing generator with built-in test-pattern source; the successor to the fixed 720p display controller.

---
 rtl/video_timing_pkg.sv | 34 +++
 rtl/video_pattern_gen.sv | 58 +++++
 rtl/hdmi_timing_pattern_gen.sv | 148 ++++++++++++++
 tb/tb_hdmi_timing_pattern_gen.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
// Package  : video_timing_pkg
// Purpose  : Pattern mode encodings, colour-bar table and timing helpers.
// Revision : 1.0
// ============================================================================
package video_timing_pkg;

  localparam logic [1:0] MODE_SOLID = 2'd0;
  localparam logic [1:0] MODE_BARS  = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;
  localparam logic [1:0] MODE_RAMP  = 2'd3;

  // {R,G,B} on/off flags per bar; index 0 is the leftmost bar (white)
  localparam logic [7:0][2:0] BAR_TABLE = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  function automatic int calc_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int calc_sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  function automatic int calc_sync_end(input int active, input int fp,
                                       input int sync);
    return active + fp + sync;
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_pattern_gen
// Purpose  : Combinational test-pattern source; zero outside the active area.
// Revision : 1.0
// ============================================================================
module video_pattern_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int CNT_W    = 12,
  parameter int COLOR_W  = 8
) (
  input  logic [CNT_W-1:0]     h,
  input  logic [CNT_W-1:0]     v,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  output logic [3*COLOR_W-1:0] rgb
);

  localparam int               C_BAR_W = H_ACTIVE / 8;
  localparam logic [CNT_W-1:0] C_H_ACT = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] C_V_ACT = CNT_W'(V_ACTIVE);

  logic [2:0]         w_bar_idx;
  logic [2:0]         w_bar_flags;
  logic               w_active;
  logic [COLOR_W-1:0] w_ramp;

  // Bar index by threshold chain so no divider is synthesised
  always_comb begin
    w_bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (h >= CNT_W'(i * C_BAR_W)) w_bar_idx = 3'(i);
    end
  end

  assign w_bar_flags = BAR_TABLE[w_bar_idx];
  assign w_active    = (h < C_H_ACT) && (v < C_V_ACT);
  assign w_ramp      = h[COLOR_W+1:2];

  always_comb begin
    rgb = '0;
    if (w_active) begin
      case (mode)
        MODE_SOLID: rgb = solid_rgb;
        MODE_BARS:  rgb = {{COLOR_W{w_bar_flags[2]}},
                           {COLOR_W{w_bar_flags[1]}},
                           {COLOR_W{w_bar_flags[0]}}};
        MODE_CHECK: rgb = {(3*COLOR_W){h[5] ^ v[5]}};
        MODE_RAMP:  rgb = {3{w_ramp}};
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/hdmi_timing_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_timing_pattern_gen
// Purpose  : Parametrised video timing generator with registered pattern out.
// Revision : 1.0
// ============================================================================
module hdmi_timing_pattern_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CNT_W    = 12,
  parameter int COLOR_W  = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 data_enable,
  output logic [3*COLOR_W-1:0] rgb_data,
  output logic [CNT_W-1:0]     pix_x,
  output logic [CNT_W-1:0]     pix_y,
  output logic                 frame_start,
  output logic                 line_start
);

  localparam int C_H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int C_V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] C_H_LAST   = CNT_W'(C_H_TOTAL - 1);
  localparam logic [CNT_W-1:0] C_V_LAST   = CNT_W'(C_V_TOTAL - 1);
  localparam logic [CNT_W-1:0] C_H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] C_V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] C_HS_START = CNT_W'(calc_sync_start(H_ACTIVE, H_FP));
  localparam logic [CNT_W-1:0] C_HS_END   = CNT_W'(calc_sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [CNT_W-1:0] C_VS_START = CNT_W'(calc_sync_start(V_ACTIVE, V_FP));
  localparam logic [CNT_W-1:0] C_VS_END   = CNT_W'(calc_sync_end(V_ACTIVE, V_FP, V_SYNC));

  logic [CNT_W-1:0]     r_h;
  logic [CNT_W-1:0]     r_v;
  logic [1:0]           r_mode;
  logic [3*COLOR_W-1:0] r_solid;

  logic                 r_hsync;
  logic                 r_vsync;
  logic                 r_de;
  logic [3*COLOR_W-1:0] r_rgb;
  logic [CNT_W-1:0]     r_pix_x;
  logic [CNT_W-1:0]     r_pix_y;
  logic                 r_frame_start;
  logic                 r_line_start;

  logic                 w_origin;
  logic                 w_h_wrap;
  logic [1:0]           w_mode;
  logic [3*COLOR_W-1:0] w_solid;
  logic                 w_hs_act;
  logic                 w_vs_act;
  logic                 w_de;
  logic [3*COLOR_W-1:0] w_rgb;

  assign w_origin = (r_h == '0) && (r_v == '0);
  assign w_h_wrap = (r_h == C_H_LAST);
  // At the origin the fresh inputs are used so pixel (0,0) already shows the new frame's pattern
  assign w_mode   = w_origin ? mode      : r_mode;
  assign w_solid  = w_origin ? solid_rgb : r_solid;
  assign w_hs_act = (r_h >= C_HS_START) && (r_h < C_HS_END);
  assign w_vs_act = (r_v >= C_VS_START) && (r_v < C_VS_END);
  assign w_de     = (r_h < C_H_ACT) && (r_v < C_V_ACT);

  video_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .CNT_W    (CNT_W),
    .COLOR_W  (COLOR_W)
  ) u_pattern (
    .h         (r_h),
    .v         (r_v),
    .mode      (w_mode),
    .solid_rgb (w_solid),
    .rgb       (w_rgb)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_h           <= '0;
      r_v           <= '0;
      r_mode        <= MODE_SOLID;
      r_solid       <= '0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_de          <= 1'b0;
      r_rgb         <= '0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
    end else if (!enable) begin
      r_h           <= '0;
      r_v           <= '0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_de          <= 1'b0;
      r_rgb         <= '0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
    end else begin
      if (w_origin) begin
        r_mode  <= mode;
        r_solid <= solid_rgb;
      end
      r_h <= w_h_wrap ? '0 : r_h + 1'b1;
      if (w_h_wrap) r_v <= (r_v == C_V_LAST) ? '0 : r_v + 1'b1;
      r_hsync       <= w_hs_act ? HS_POL : ~HS_POL;
      r_vsync       <= w_vs_act ? VS_POL : ~VS_POL;
      r_de          <= w_de;
      r_rgb         <= w_rgb;
      r_pix_x       <= r_h;
      r_pix_y       <= r_v;
      r_frame_start <= w_origin;
      r_line_start  <= (r_h == '0);
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign data_enable = r_de;
  assign rgb_data    = r_rgb;
  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;
  assign frame_start = r_frame_start;
  assign line_start  = r_line_start;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_timing_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdmi_timing_pattern_gen
// Purpose  : Bench for a default 720p instance and a miniature-timing instance.
// Revision : 1.0
// ============================================================================
module tb_hdmi_timing_pattern_gen;
  import video_timing_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Instance A: default 720p timing
  logic        rst_a_n, en_a;
  logic [1:0]  mode_a;
  logic [23:0] solid_a, rgb_a;
  logic        hsync_a, vsync_a, de_a, fs_a, ls_a;
  logic [11:0] px_a, py_a;

  // Instance B: 14x7 timing, negative syncs
  logic        rst_b_n, en_b;
  logic [1:0]  mode_b;
  logic [23:0] solid_b, rgb_b;
  logic        hsync_b, vsync_b, de_b, fs_b, ls_b;
  logic [11:0] px_b, py_b;

  hdmi_timing_pattern_gen u_dut_a (
    .clock(clk), .reset_n(rst_a_n), .enable(en_a), .mode(mode_a), .solid_rgb(solid_a),
    .hsync(hsync_a), .vsync(vsync_a), .data_enable(de_a), .rgb_data(rgb_a),
    .pix_x(px_a), .pix_y(py_a), .frame_start(fs_a), .line_start(ls_a)
  );

  hdmi_timing_pattern_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(12), .COLOR_W(8)
  ) u_dut_b (
    .clock(clk), .reset_n(rst_b_n), .enable(en_b), .mode(mode_b), .solid_rgb(solid_b),
    .hsync(hsync_b), .vsync(vsync_b), .data_enable(de_b), .rgb_data(rgb_b),
    .pix_x(px_b), .pix_y(py_b), .frame_start(fs_b), .line_start(ls_b)
  );

  // ---------------- scoreboard model for instance B ----------------
  logic [52:0] q_b [$];
  bit          sb_on = 1'b0;
  logic [11:0] mh = '0, mv = '0;
  logic [1:0]  mmode = '0;
  logic [23:0] msolid = '0;
  logic [52:0] mexp;

  function automatic logic [23:0] exp_rgb_b(input logic [1:0] m, input logic [23:0] s,
                                            input logic [11:0] x, input logic [11:0] y);
    int idx;
    if (!(x < 12'd8 && y < 12'd4)) return 24'h0;
    case (m)
      2'd0: return s;
      2'd1: begin
        idx = int'(x) / 1;
        case (idx)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      2'd2: return (x[5] ^ y[5]) ? 24'hFFFFFF : 24'h000000;
      default: return {3{x[9:2]}};
    endcase
  endfunction

  always @(posedge clk or negedge rst_b_n) begin
    if (!rst_b_n) begin
      mh = '0; mv = '0; mmode = '0; msolid = '0;
    end else begin
      if (!en_b) begin
        mexp = {5'b11000, 48'h0};
        mh = '0; mv = '0;
      end else begin
        if (mh == 12'd0 && mv == 12'd0) begin
          mmode = mode_b; msolid = solid_b;
        end
        mexp = {!(mh >= 12'd10 && mh < 12'd12), !(mv == 12'd5),
                (mh < 12'd8 && mv < 12'd4), (mh == 12'd0 && mv == 12'd0), (mh == 12'd0),
                mh, mv, exp_rgb_b(mmode, msolid, mh, mv)};
        if (mh == 12'd13) begin
          mh = '0;
          mv = (mv == 12'd6) ? 12'd0 : mv + 12'd1;
        end else begin
          mh = mh + 12'd1;
        end
      end
      if (sb_on) q_b.push_back(mexp);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  // ---------------- helpers (no comparisons) ----------------
  task automatic restart_a(input logic [1:0] m, input logic [23:0] s);
    @(negedge clk); en_a = 1'b0; mode_a = m; solid_a = s;
    @(negedge clk); en_a = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_pix_a(input logic [11:0] x, input logic [11:0] y, input int budget,
                            output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (px_a == x && py_a == y) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [52:0] act;
    act = {hsync_a, vsync_a, de_a, fs_a, ls_a, px_a, py_a, rgb_a};
    n_checks++;
    if (act !== 53'h0) $display("FAIL reset_state_a: got %h, expected 0", act);
    else n_pass++;
    act = {hsync_b, vsync_b, de_b, fs_b, ls_b, px_b, py_b, rgb_b};
    n_checks++;
    if (act !== {5'b11000, 48'h0}) $display("FAIL reset_state_b: got %h, expected %h", act, {5'b11000, 48'h0});
    else n_pass++;

    @(negedge clk); rst_a_n = 1'b1; rst_b_n = 1'b1; mode_a = MODE_RAMP; en_a = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({fs_a, ls_a, px_a, py_a} !== {1'b1, 1'b1, 12'd0, 12'd0})
      $display("FAIL release_frame_start: got fs=%b ls=%b x=%0d y=%0d, expected fs=1 ls=1 x=0 y=0", fs_a, ls_a, px_a, py_a);
    else n_pass++;

    repeat (60) @(negedge clk);
    n_checks++;
    if ({px_a, de_a, rgb_a} !== {12'd60, 1'b1, 24'h0F0F0F})
      $display("FAIL ramp_before_reset: got x=%0d de=%b rgb=%h, expected x=60 de=1 rgb=0f0f0f", px_a, de_a, rgb_a);
    else n_pass++;

    #2 rst_a_n = 1'b0;
    #1;
    act = {hsync_a, vsync_a, de_a, fs_a, ls_a, px_a, py_a, rgb_a};
    n_checks++;
    if (act !== 53'h0) $display("FAIL async_reset: got %h, expected 0", act);
    else n_pass++;

    @(negedge clk); rst_a_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({fs_a, px_a, py_a} !== {1'b1, 12'd0, 12'd0})
      $display("FAIL post_reset_frame_start: got fs=%b x=%0d y=%0d, expected fs=1 x=0 y=0", fs_a, px_a, py_a);
    else n_pass++;
  endtask

  task automatic test_small_frame();
    logic [52:0] act, exp;
    int last_ls = -1, last_fs = -1, fc = 0;
    logic [11:0] px_prev = '0, py_prev = '0;
    bit switched = 1'b0;
    @(negedge clk); en_b = 1'b0; mode_b = MODE_SOLID; solid_b = 24'h123456;
    @(negedge clk); q_b.delete(); sb_on = 1'b1; en_b = 1'b1;
    for (int cyc = 0; cyc < 3 * 98; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (q_b.size() == 0) $display("FAIL sb_small: cycle %0d got output, expected queue entry", cyc);
      else begin
        exp = q_b.pop_front();
        act = {hsync_b, vsync_b, de_b, fs_b, ls_b, px_b, py_b, rgb_b};
        if (act !== exp) $display("FAIL sb_small: cycle %0d got %h, expected %h", cyc, act, exp);
        else n_pass++;
      end
      if (ls_b) begin
        if (last_ls >= 0) begin
          n_checks++;
          if (cyc - last_ls != 14) $display("FAIL line_period_small: got %0d, expected 14", cyc - last_ls);
          else n_pass++;
        end
        last_ls = cyc;
      end
      if (fs_b) begin
        fc++;
        if (last_fs >= 0) begin
          n_checks++;
          if (cyc - last_fs != 98) $display("FAIL frame_period_small: got %0d, expected 98", cyc - last_fs);
          else n_pass++;
        end
        last_fs = cyc;
      end
      n_checks++;
      if (hsync_b !== ((px_b == 12'd10 || px_b == 12'd11) ? 1'b0 : 1'b1))
        $display("FAIL hsync_small: x=%0d got %b, expected %b", px_b, hsync_b, !(px_b == 12'd10 || px_b == 12'd11));
      else n_pass++;
      if (cyc > 0 && px_prev == 12'd13) begin
        n_checks++;
        if ({px_b, ls_b} !== {12'd0, 1'b1}) $display("FAIL h_wrap_small: got x=%0d ls=%b, expected x=0 ls=1", px_b, ls_b);
        else n_pass++;
        if (py_prev == 12'd6) begin
          n_checks++;
          if ({py_b, fs_b} !== {12'd0, 1'b1}) $display("FAIL v_wrap_small: got y=%0d fs=%b, expected y=0 fs=1", py_b, fs_b);
          else n_pass++;
        end
      end
      if (fc == 1 && px_b == 12'd1 && py_b == 12'd3) begin
        n_checks++;
        if (rgb_b !== 24'h123456) $display("FAIL solid_after_switch: got %h, expected 123456", rgb_b);
        else n_pass++;
      end
      if (fc == 2 && py_b == 12'd0 && (px_b == 12'd1 || px_b == 12'd7)) begin
        n_checks++;
        if (rgb_b !== ((px_b == 12'd1) ? 24'hFFFF00 : 24'h000000))
          $display("FAIL bars_next_frame: x=%0d got %h, expected %h", px_b, rgb_b, (px_b == 12'd1) ? 24'hFFFF00 : 24'h000000);
        else n_pass++;
      end
      if (!switched && py_b == 12'd2 && px_b == 12'd0) begin
        mode_b = MODE_BARS;
        switched = 1'b1;
      end
      px_prev = px_b;
      py_prev = py_b;
    end
    sb_on = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [52:0] act, exp;
    @(negedge clk); q_b.delete(); sb_on = 1'b1; en_b = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 63) == 0) en_b = ~en_b;
      if ($urandom_range(0, 7) == 0) begin
        mode_b  = 2'($urandom_range(0, 3));
        solid_b = 24'($urandom);
      end
      @(negedge clk);
      n_checks++;
      if (q_b.size() == 0) $display("FAIL sb_b2b: cycle %0d got output, expected queue entry", cyc);
      else begin
        exp = q_b.pop_front();
        act = {hsync_b, vsync_b, de_b, fs_b, ls_b, px_b, py_b, rgb_b};
        if (act !== exp) $display("FAIL sb_b2b: cycle %0d got %h, expected %h", cyc, act, exp);
        else n_pass++;
      end
    end
    sb_on = 1'b0;
  endtask

  task automatic test_line_timing();
    int last_ls = -1, de_cnt = 0, hs_len = 0;
    bit hs_prev = 1'b0;
    restart_a(MODE_SOLID, 24'hA5C33C);
    for (int cyc = 0; cyc < 3 * 1650 + 1; cyc++) begin
      if (ls_a) begin
        n_checks++;
        if (vsync_a !== 1'b0) $display("FAIL vsync_idle: y=%0d got %b, expected 0", py_a, vsync_a);
        else n_pass++;
        if (last_ls >= 0) begin
          n_checks++;
          if (cyc - last_ls != 1650) $display("FAIL line_period: got %0d, expected 1650", cyc - last_ls);
          else n_pass++;
          n_checks++;
          if (de_cnt != 1280) $display("FAIL de_per_line: got %0d, expected 1280", de_cnt);
          else n_pass++;
        end
        last_ls = cyc;
        de_cnt = 0;
      end
      if (de_a) de_cnt++;
      if (hsync_a && !hs_prev) begin
        n_checks++;
        if (px_a !== 12'd1390) $display("FAIL hsync_start: got x=%0d, expected 1390", px_a);
        else n_pass++;
      end
      if (hsync_a) hs_len++;
      if (!hsync_a && hs_prev) begin
        n_checks++;
        if (hs_len != 40) $display("FAIL hsync_width: got %0d, expected 40", hs_len);
        else n_pass++;
        hs_len = 0;
      end
      if (px_a == 12'd5 || px_a == 12'd1300) begin
        n_checks++;
        if (rgb_a !== ((px_a == 12'd5) ? 24'hA5C33C : 24'h0))
          $display("FAIL solid_rgb: x=%0d got %h, expected %h", px_a, rgb_a, (px_a == 12'd5) ? 24'hA5C33C : 24'h0);
        else n_pass++;
      end
      hs_prev = hsync_a;
      @(negedge clk);
    end
  endtask

  task automatic test_bars_default();
    int          bx [9] = '{0, 159, 160, 320, 480, 640, 800, 1119, 1279};
    logic [23:0] be [9] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    bit ok;
    restart_a(MODE_BARS, 24'h0);
    for (int i = 0; i < 9; i++) begin
      wait_pix_a(12'(bx[i]), 12'd0, 1700, ok);
      n_checks++;
      if (!ok || rgb_a !== be[i]) $display("FAIL bars_default: x=%0d reached=%b got %h, expected %h", bx[i], ok, rgb_a, be[i]);
      else n_pass++;
    end
  endtask

  task automatic test_check_ramp();
    int          rx [5] = '{3, 4, 1023, 1024, 1279};
    logic [23:0] re [5] = '{24'h000000, 24'h010101, 24'hFFFFFF, 24'h000000, 24'h3F3F3F};
    int          cx [4] = '{31, 32, 0, 32};
    int          cy [4] = '{0, 0, 32, 32};
    logic [23:0] ce [4] = '{24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'h000000};
    bit ok;
    restart_a(MODE_RAMP, 24'h0);
    for (int i = 0; i < 5; i++) begin
      wait_pix_a(12'(rx[i]), 12'd0, 1700, ok);
      n_checks++;
      if (!ok || rgb_a !== re[i]) $display("FAIL grey_ramp: x=%0d reached=%b got %h, expected %h", rx[i], ok, rgb_a, re[i]);
      else n_pass++;
    end
    restart_a(MODE_CHECK, 24'h0);
    for (int i = 0; i < 4; i++) begin
      wait_pix_a(12'(cx[i]), 12'(cy[i]), 60000, ok);
      n_checks++;
      if (!ok || rgb_a !== ce[i])
        $display("FAIL checker: (%0d,%0d) reached=%b got %h, expected %h", cx[i], cy[i], ok, rgb_a, ce[i]);
      else n_pass++;
    end
  endtask

  task automatic test_enable_drop();
    logic [52:0] act;
    bit ok;
    restart_a(MODE_BARS, 24'h0);
    wait_pix_a(12'd500, 12'd10, 20000, ok);
    n_checks++;
    if (!ok) $display("FAIL reach_500_10: got timeout, expected pixel (500,10)");
    else n_pass++;
    en_a = 1'b0;
    @(negedge clk);
    act = {hsync_a, vsync_a, de_a, fs_a, ls_a, px_a, py_a, rgb_a};
    n_checks++;
    if (act !== 53'h0) $display("FAIL idle_after_drop: got %h, expected 0", act);
    else n_pass++;
    repeat (3) @(negedge clk);
    act = {hsync_a, vsync_a, de_a, fs_a, ls_a, px_a, py_a, rgb_a};
    n_checks++;
    if (act !== 53'h0) $display("FAIL idle_hold: got %h, expected 0", act);
    else n_pass++;
    en_a = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({fs_a, ls_a, de_a, px_a, py_a, rgb_a} !== {3'b111, 12'd0, 12'd0, 24'hFFFFFF})
      $display("FAIL restart_origin: got fs=%b ls=%b de=%b x=%0d y=%0d rgb=%h, expected 1 1 1 0 0 ffffff",
               fs_a, ls_a, de_a, px_a, py_a, rgb_a);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({fs_a, px_a} !== {1'b0, 12'd1}) $display("FAIL restart_advance: got fs=%b x=%0d, expected fs=0 x=1", fs_a, px_a);
    else n_pass++;
  endtask

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    en_a = 1'b0; en_b = 1'b0;
    mode_a = MODE_SOLID; mode_b = MODE_SOLID;
    solid_a = 24'h0; solid_b = 24'h0;
    repeat (2) @(negedge clk);
    test_reset();
    test_small_frame();
    test_back_to_back();
    test_line_timing();
    test_bars_default();
    test_check_ramp();
    test_enable_drop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
